axi4_to_native_bridge: RTL and testbench

Parametrised AXI4 slave to DDR-controller native (app_*) bridge; next generation of the single-width DDR bridge. Adds internal parametrised FIFOs (no vendor FIFO IP), WSTRB-to-mask translation, credit-limited read issue so read data can never overflow, fair write/read arbitration, and a parametrised address step. Sits between the VDMA AXI4 master and the memory controller user interface.

---
 rtl/axi4_to_native_bridge.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axi4_to_native_bridge.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_to_native_bridge.sv
// AXI4 slave to DDR-controller native (app_*) bridge: one app command per AXI beat,
// internal write/read data FIFOs, credit-limited read issue and fair write/read arbitration.

module axi4_to_native_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define which
  // entries are valid, so a flush only needs to clear those.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module axi4_to_native_bridge #(
  parameter int ADDR_WIDTH  = 27,
  parameter int DATA_WIDTH  = 256,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_STEP   = 8,
  parameter int WFIFO_DEPTH = 16,
  parameter int RFIFO_DEPTH = 32
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [ID_WIDTH-1:0]     axi_rid,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  input  logic                    app_rd_data_end,
  input  logic                    init_calib_complete,
  output logic                    err_rd_overflow
);
  localparam int MW = DATA_WIDTH / 8;
  localparam logic [2:0] CMD_WR  = 3'b000;
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [9:0] RDEPTH  = 10'(RFIFO_DEPTH);

  typedef enum logic [2:0] {
    S_CALIB, S_IDLE, S_WR_DATA, S_WR_DRAIN, S_WR_RESP, S_RD_ISSUE
  } state_t;

  state_t                r_state;
  logic                  r_last_wr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [8:0]            r_beats_n;
  logic [8:0]            r_beats_in;
  logic [8:0]            r_beats_out;
  logic [8:0]            r_cmds;
  logic                  r_app_en;
  logic [ADDR_WIDTH-1:0] r_app_addr;
  logic [2:0]            r_app_cmd;
  logic                  r_bvalid;
  logic                  r_err;

  logic                  w_aw_grant;
  logic                  w_ar_grant;
  logic                  w_wpush;
  logic                  w_wpop;
  logic                  w_wempty;
  logic                  w_wfull;
  logic [DATA_WIDTH+MW-1:0] w_whead;
  logic                  w_rpop;
  logic                  w_rempty;
  logic                  w_rfull;
  logic                  w_cmd_acc;
  logic [8:0]            w_cmds_next;
  logic [8:0]            w_out_next;
  logic [8:0]            w_pending_next;
  logic                  w_wr_issue;
  logic                  w_rd_issue;
  logic                  w_unused;

  // Both valid: grant the opposite of the previous grant; reset state favours write.
  assign w_aw_grant = (r_state == S_IDLE) && init_calib_complete && axi_awvalid &&
                      (!axi_arvalid || !r_last_wr);
  assign w_ar_grant = (r_state == S_IDLE) && init_calib_complete && axi_arvalid &&
                      (!axi_awvalid || r_last_wr);

  assign axi_awready = w_aw_grant;
  assign axi_arready = w_ar_grant;
  assign axi_wready  = (r_state == S_WR_DATA) && !w_wfull && (r_beats_in < r_beats_n);
  assign w_wpush     = axi_wvalid && axi_wready;
  assign w_wpop      = app_wdf_wren && app_wdf_rdy;

  axi4_to_native_bridge_fifo #(.WIDTH(DATA_WIDTH + MW), .DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clock   (clock),
    .rst     (rst),
    .i_push  (w_wpush),
    .i_data  ({axi_wdata, ~axi_wstrb}),
    .i_pop   (w_wpop),
    .o_data  (w_whead),
    .o_empty (w_wempty),
    .o_full  (w_wfull)
  );

  assign app_wdf_data = w_whead[DATA_WIDTH+MW-1:MW];
  assign app_wdf_mask = w_whead[MW-1:0];
  assign app_wdf_wren = !w_wempty;
  assign app_wdf_end  = app_wdf_wren;

  axi4_to_native_bridge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clock   (clock),
    .rst     (rst),
    .i_push  (app_rd_data_valid),
    .i_data  (app_rd_data),
    .i_pop   (w_rpop),
    .o_data  (axi_rdata),
    .o_empty (w_rempty),
    .o_full  (w_rfull)
  );

  assign axi_rvalid = !w_rempty;
  assign w_rpop     = axi_rvalid && axi_rready;
  assign axi_rlast  = axi_rvalid && (r_beats_out == r_beats_n - 9'd1);
  assign axi_rid    = r_id;
  assign axi_rresp  = 2'b00;
  assign axi_bid    = r_id;
  assign axi_bresp  = 2'b00;
  assign axi_bvalid = r_bvalid;

  // Every app beat is a single-beat burst, so the end marker and wlast carry no extra information.
  assign w_unused = ^{app_rd_data_end, axi_wlast};

  // Issue decisions look one cycle ahead so that app_en only drops after acceptance.
  assign w_cmd_acc      = r_app_en && app_rdy;
  assign w_cmds_next    = r_cmds + {8'd0, w_cmd_acc};
  assign w_out_next     = r_beats_out + {8'd0, w_rpop};
  assign w_pending_next = w_cmds_next - w_out_next;
  assign w_wr_issue     = ((r_state == S_WR_DATA) || (r_state == S_WR_DRAIN)) &&
                          (w_cmds_next < r_beats_n) && (r_beats_in > w_cmds_next);
  assign w_rd_issue     = (r_state == S_RD_ISSUE) && (w_cmds_next < r_beats_n) &&
                          ({1'b0, w_pending_next} < RDEPTH);

  assign app_en          = r_app_en;
  assign app_addr        = r_app_addr;
  assign app_cmd         = r_app_cmd;
  assign err_rd_overflow = r_err;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= S_CALIB;
      r_last_wr   <= 1'b0;
      r_id        <= '0;
      r_beats_n   <= '0;
      r_beats_in  <= '0;
      r_beats_out <= '0;
      r_cmds      <= '0;
      r_app_en    <= 1'b0;
      r_app_addr  <= '0;
      r_app_cmd   <= CMD_NOP;
      r_bvalid    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_cmd_acc) r_app_addr <= r_app_addr + ADDR_WIDTH'(ADDR_STEP);
      if (w_wpush)   r_beats_in <= r_beats_in + 9'd1;
      if (app_rd_data_valid && w_rfull) r_err <= 1'b1;
      r_cmds      <= w_cmds_next;
      r_beats_out <= w_out_next;
      r_app_en    <= (r_app_en && !app_rdy) || w_wr_issue || w_rd_issue;

      case (r_state)
        S_CALIB: if (init_calib_complete) r_state <= S_IDLE;
        S_IDLE: begin
          if (!init_calib_complete) begin
            r_state <= S_CALIB;
          end else if (w_aw_grant) begin
            r_state     <= S_WR_DATA;
            r_last_wr   <= 1'b1;
            r_id        <= axi_awid;
            r_beats_n   <= {1'b0, axi_awlen} + 9'd1;
            r_app_addr  <= axi_awaddr;
            r_app_cmd   <= CMD_WR;
            r_cmds      <= '0;
            r_beats_in  <= '0;
            r_beats_out <= '0;
          end else if (w_ar_grant) begin
            r_state     <= S_RD_ISSUE;
            r_last_wr   <= 1'b0;
            r_id        <= axi_arid;
            r_beats_n   <= {1'b0, axi_arlen} + 9'd1;
            r_app_addr  <= axi_araddr;
            r_app_cmd   <= CMD_RD;
            r_cmds      <= '0;
            r_beats_in  <= '0;
            r_beats_out <= '0;
          end
        end
        S_WR_DATA:  if (r_beats_in == r_beats_n) r_state <= S_WR_DRAIN;
        S_WR_DRAIN: begin
          if ((r_cmds == r_beats_n) && w_wempty) begin
            r_state  <= S_WR_RESP;
            r_bvalid <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (axi_bready) begin
            r_state  <= S_IDLE;
            r_bvalid <= 1'b0;
          end
        end
        S_RD_ISSUE: if (w_rpop && axi_rlast) r_state <= S_IDLE;
        default:    r_state <= S_CALIB;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_to_native_bridge.sv
// Directed bench for axi4_to_native_bridge: a simple memory-controller model answers reads
// and monitors log every handshake for comparison against hand-computed expectations.

module tb_axi4_to_native_bridge;
  localparam int AW = 27;
  localparam int DW = 256;
  localparam int IW = 4;
  localparam int MW = DW / 8;

  logic          clock = 1'b0;
  logic          rst;
  logic [IW-1:0] axi_awid;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [DW-1:0] axi_wdata;
  logic [MW-1:0] axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [IW-1:0] axi_bid;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [IW-1:0] axi_arid;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [IW-1:0] axi_rid;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;
  logic          err_rd_overflow;
  logic          rdy_toggle;

  int n_checks = 0;
  int n_pass   = 0;
  int hold_viol = 0;

  logic [AW-1:0] q_cmd_addr[$];
  logic [2:0]    q_cmd_type[$];
  logic [DW-1:0] q_wdata[$];
  logic [MW-1:0] q_wmask[$];
  logic [DW-1:0] q_rdata[$];
  logic          q_rlast[$];
  logic [IW-1:0] q_rid[$];
  logic [IW-1:0] q_bid[$];
  logic [1:0]    q_bresp[$];
  logic [7:0]    q_grant[$];
  logic [AW-1:0] rd_pend[$];
  logic          prev_en;
  logic          prev_rdy;
  logic [AW-1:0] prev_addr;

  axi4_to_native_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .ADDR_STEP(8), .WFIFO_DEPTH(16), .RFIFO_DEPTH(32)
  ) dut (
    .clock(clock), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .init_calib_complete(init_calib_complete), .err_rd_overflow(err_rd_overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] wpat(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  function automatic logic [DW-1:0] rpat(input logic [AW-1:0] a);
    return {8{{5'b0, a}}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Handshake monitor: inputs change just after posedge, so values at negedge are what the next edge uses.
  always @(negedge clock) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (prev_en && !prev_rdy && (!app_en || app_addr != prev_addr)) hold_viol++;
      prev_en   = app_en;
      prev_rdy  = app_rdy;
      prev_addr = app_addr;
      if (app_en && app_rdy) begin
        q_cmd_addr.push_back(app_addr);
        q_cmd_type.push_back(app_cmd);
        if (app_cmd == 3'b001) rd_pend.push_back(app_addr);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        q_wdata.push_back(app_wdf_data);
        q_wmask.push_back(app_wdf_mask);
      end
      if (axi_rvalid && axi_rready) begin
        q_rdata.push_back(axi_rdata);
        q_rlast.push_back(axi_rlast);
        q_rid.push_back(axi_rid);
      end
      if (axi_bvalid && axi_bready) begin
        q_bid.push_back(axi_bid);
        q_bresp.push_back(axi_bresp);
      end
      if (axi_awvalid && axi_awready) q_grant.push_back("W");
      if (axi_arvalid && axi_arready) q_grant.push_back("R");
    end
  end

  // Controller model: returns one read beat per cycle (data derived from address); app_rdy source.
  always @(posedge clock) begin
    #1;
    if (rst) begin
      rd_pend.delete();
      app_rd_data_valid = 1'b0;
      app_rd_data_end   = 1'b0;
      app_rd_data       = '0;
    end else if (rd_pend.size() > 0) begin
      app_rd_data       = rpat(rd_pend[0]);
      app_rd_data_valid = 1'b1;
      app_rd_data_end   = 1'b1;
      void'(rd_pend.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data_end   = 1'b0;
    end
    app_rdy = rdy_toggle ? ~app_rdy : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    q_cmd_addr.delete(); q_cmd_type.delete(); q_wdata.delete(); q_wmask.delete();
    q_rdata.delete(); q_rlast.delete(); q_rid.delete(); q_bid.delete(); q_bresp.delete();
    q_grant.delete();
  endtask

  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    bit ok = 1'b0;
    @(posedge clock); #1;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awvalid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      ok = axi_awready;
    end
    @(posedge clock); #1;
    axi_awvalid = 1'b0;
    check("aw_handshake", 256'(ok), 256'd1);
  endtask

  task automatic do_w(input logic [DW-1:0] data, input logic [MW-1:0] strb, input logic last);
    bit ok = 1'b0;
    @(posedge clock); #1;
    axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      ok = axi_wready;
    end
    @(posedge clock); #1;
    axi_wvalid = 1'b0;
    check("w_handshake", 256'(ok), 256'd1);
  endtask

  task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    bit ok = 1'b0;
    @(posedge clock); #1;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arvalid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      ok = axi_arready;
    end
    @(posedge clock); #1;
    axi_arvalid = 1'b0;
    check("ar_handshake", 256'(ok), 256'd1);
  endtask

  initial begin
    logic [AW-1:0] a;
    rst = 1'b1; init_calib_complete = 1'b0; rdy_toggle = 1'b0;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b1;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    app_wdf_rdy = 1'b1;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_app_cmd", 256'(app_cmd), 256'(3'b111));
    check("rst_app_en", 256'(app_en), 256'd0);
    check("rst_wren", 256'(app_wdf_wren), 256'd0);
    check("rst_bvalid", 256'(axi_bvalid), 256'd0);
    check("rst_rvalid", 256'(axi_rvalid), 256'd0);
    check("rst_err", 256'(err_rd_overflow), 256'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    axi_awvalid = 1'b1;
    repeat (3) @(negedge clock);
    check("calib_blocks_aw", 256'(axi_awready), 256'd0);
    check("calib_no_grant", 256'(q_grant.size()), 256'd0);
    @(posedge clock); #1;
    axi_awvalid = 1'b0;
    init_calib_complete = 1'b1;
    repeat (2) @(negedge clock);

    // Write awlen=3 at 0x100, full strobes
    clear_q();
    do_aw(4'h5, 27'h100, 8'd3);
    for (int i = 0; i < 4; i++) do_w(wpat(32'hA500_0000 + 32'(i)), '1, i == 3);
    for (int i = 0; i < 3000 && q_bid.size() < 1; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    check("w1_cmd_count", 256'(q_cmd_addr.size()), 256'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("w1_addr%0d", k), 256'(q_cmd_addr[k]), 256'(27'h100 + 27'(8 * k)));
      check($sformatf("w1_cmd%0d", k), 256'(q_cmd_type[k]), 256'd0);
      check($sformatf("w1_data%0d", k), q_wdata[k], wpat(32'hA500_0000 + 32'(k)));
      check($sformatf("w1_mask%0d", k), 256'(q_wmask[k]), 256'd0);
    end
    check("w1_wdata_count", 256'(q_wdata.size()), 256'd4);
    check("w1_b_count", 256'(q_bid.size()), 256'd1);
    check("w1_bid", 256'(q_bid[0]), 256'h5);
    check("w1_bresp", 256'(q_bresp[0]), 256'd0);

    // Single-beat write with partial strobes
    clear_q();
    do_aw(4'h9, 27'h2000, 8'd0);
    do_w(wpat(32'h1234_5678), 32'h0000_000F, 1'b1);
    for (int i = 0; i < 3000 && q_bid.size() < 1; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("w2_cmd_count", 256'(q_cmd_addr.size()), 256'd1);
    check("w2_addr", 256'(q_cmd_addr[0]), 256'h2000);
    check("w2_mask", 256'(q_wmask[0]), 256'hFFFF_FFF0);
    check("w2_data", q_wdata[0], wpat(32'h1234_5678));
    check("w2_bid", 256'(q_bid[0]), 256'h9);

    // Read arlen=63 against a 32-deep read FIFO with rready low
    clear_q();
    do_ar(4'h3, 27'h4000, 8'd63);
    repeat (200) @(negedge clock);
    check("r1_credit_stall", 256'(q_cmd_addr.size()), 256'd32);
    check("r1_no_beats", 256'(q_rdata.size()), 256'd0);
    check("r1_rvalid", 256'(axi_rvalid), 256'd1);
    check("r1_no_overflow", 256'(err_rd_overflow), 256'd0);
    @(posedge clock); #1;
    axi_rready = 1'b1;
    for (int i = 0; i < 3000 && q_rdata.size() < 64; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    check("r1_beat_count", 256'(q_rdata.size()), 256'd64);
    check("r1_cmd_count", 256'(q_cmd_addr.size()), 256'd64);
    for (int k = 0; k < 64; k++) begin
      a = 27'h4000 + 27'(8 * k);
      check($sformatf("r1_data%0d", k), q_rdata[k], rpat(a));
      check($sformatf("r1_last%0d", k), 256'(q_rlast[k]), 256'(k == 63));
    end
    check("r1_rid", 256'(q_rid[0]), 256'h3);
    check("r1_cmd_type", 256'(q_cmd_type[0]), 256'd1);

    // Both AW and AR pending: grants must alternate, write first after a read
    clear_q();
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          do_aw(4'h1, 27'h8000 + 27'(64 * i), 8'd0);
          do_w(wpat(32'hBEEF_0000 + 32'(i)), '1, 1'b1);
        end
      end
      begin
        for (int j = 0; j < 2; j++) do_ar(4'h2, 27'hC000 + 27'(64 * j), 8'd0);
      end
    join
    for (int i = 0; i < 3000 && (q_bid.size() < 2 || q_rdata.size() < 2); i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("arb_count", 256'(q_grant.size()), 256'd4);
    check("arb_g0", 256'(q_grant[0]), 256'("W"));
    check("arb_g1", 256'(q_grant[1]), 256'("R"));
    check("arb_g2", 256'(q_grant[2]), 256'("W"));
    check("arb_g3", 256'(q_grant[3]), 256'("R"));
    check("arb_rdata0", q_rdata[0], rpat(27'hC000));

    // app_rdy toggling during an 8-beat write crossing the address wrap
    clear_q();
    @(posedge clock); #1;
    rdy_toggle = 1'b1;
    do_aw(4'h6, 27'h7FF_FFF0, 8'd7);
    for (int i = 0; i < 8; i++) do_w(wpat(32'hC0DE_0000 + 32'(i)), '1, i == 7);
    for (int i = 0; i < 3000 && q_bid.size() < 1; i++) @(negedge clock);
    @(posedge clock); #1;
    rdy_toggle = 1'b0;
    repeat (3) @(negedge clock);
    check("tg_cmd_count", 256'(q_cmd_addr.size()), 256'd8);
    for (int k = 0; k < 8; k++) begin
      a = 27'h7FF_FFF0 + 27'(8 * k);
      check($sformatf("tg_addr%0d", k), 256'(q_cmd_addr[k]), 256'(a));
      check($sformatf("tg_data%0d", k), q_wdata[k], wpat(32'hC0DE_0000 + 32'(k)));
    end
    check("tg_wdata_count", 256'(q_wdata.size()), 256'd8);
    check("tg_hold_violations", 256'(hold_viol), 256'd0);
    check("tg_bid", 256'(q_bid[0]), 256'h6);

    // Reset in the middle of a read burst, then a fresh burst after calibration
    clear_q();
    @(posedge clock); #1;
    axi_rready = 1'b0;
    do_ar(4'h7, 27'h400, 8'd15);
    repeat (10) @(negedge clock);
    check("mid_rvalid_before", 256'(axi_rvalid), 256'd1);
    @(posedge clock); #2;
    rst = 1'b1;
    init_calib_complete = 1'b0;
    #1;
    check("mid_app_cmd", 256'(app_cmd), 256'(3'b111));
    check("mid_app_en", 256'(app_en), 256'd0);
    check("mid_rvalid", 256'(axi_rvalid), 256'd0);
    check("mid_rlast", 256'(axi_rlast), 256'd0);
    check("mid_app_addr", 256'(app_addr), 256'd0);
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    axi_arvalid = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_calib_blocks_ar", 256'(axi_arready), 256'd0);
    @(posedge clock); #1;
    axi_arvalid = 1'b0;
    init_calib_complete = 1'b1;
    axi_rready = 1'b1;
    clear_q();
    repeat (2) @(negedge clock);
    do_ar(4'hA, 27'h200, 8'd3);
    for (int i = 0; i < 3000 && q_rdata.size() < 4; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    check("post_beat_count", 256'(q_rdata.size()), 256'd4);
    for (int k = 0; k < 4; k++) begin
      a = 27'h200 + 27'(8 * k);
      check($sformatf("post_data%0d", k), q_rdata[k], rpat(a));
      check($sformatf("post_last%0d", k), 256'(q_rlast[k]), 256'(k == 3));
    end
    check("post_rid", 256'(q_rid[0]), 256'hA);
    check("post_no_overflow", 256'(err_rd_overflow), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
